// File: rtl/db_shift_ctrl_if.sv
// Upstream database-word stream handshake into the shift controller.
// Only the control side of the stream lives here; the 512-bit payload goes
// straight to the shift register, which is loaded when the controller pulses `load`.
interface db_shift_ctrl_if;
    logic in_valid;   // upstream word available
    logic in_last;    // current word is the final database word
    logic in_ready;   // controller accepts the word this cycle

    modport master (output in_valid, output in_last, input in_ready);
    modport slave  (input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/db_shift_ctrl.sv
// Sequencer for the database shift register of the seed-matching datapath.
// Presents one nucleotide per cycle. Each new word is loaded in the same
// cycle as the final shift of the previous word, so the overlap residue in
// the register is never lost. Also tracks the absolute position of the
// window head.
module db_shift_ctrl #(
    parameter int DATA_W = 512,
    parameter int POS_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    db_shift_ctrl_if.slave   up,
    input  logic             hold,
    output logic             load,
    output logic             shift,
    output logic [8:0]       shift_no,
    output logic             stop,
    output logic             win_valid,
    output logic [POS_W-1:0] db_pos,
    output logic             busy,
    output logic             done
);

    // Index of the final nucleotide in a word (2 bits per nucleotide).
    localparam logic [8:0] LAST_IDX = 9'(DATA_W / 2 - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_STARVE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             in_ready_c;

    // Next-state and control decode.
    // NOTE: every output and next-state variable gets a default before the
    // case statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        pos_d      = pos_q;
        load       = 1'b0;
        shift      = 1'b0;
        stop       = 1'b0;
        in_ready_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_d   = '0;
                    state_d = S_FILL;
                end
            end

            // First word: load only. The register holds no data yet, so
            // there is nothing to shift, and hold has no meaning here.
            S_FILL: begin
                in_ready_c = 1'b1;
                if (up.in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    last_d  = up.in_last;
                    state_d = S_RUN;
                end
            end

            // Hold wins over everything, including a pending word boundary.
            S_RUN: begin
                if (hold) begin
                    stop = 1'b1;
                end else if (cnt_q < LAST_IDX) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 9'd1;
                    pos_d = pos_q + POS_ONE;
                end else if (last_q) begin
                    shift   = 1'b1;
                    pos_d   = pos_q + POS_ONE;
                    state_d = S_DONE;
                end else if (up.in_valid) begin
                    // Boundary: the final shift and the next load share one cycle.
                    load       = 1'b1;
                    shift      = 1'b1;
                    in_ready_c = 1'b1;
                    cnt_d      = '0;
                    last_d     = up.in_last;
                    pos_d      = pos_q + POS_ONE;
                end else begin
                    // Never cross the boundary without a load; wait for data.
                    state_d = S_STARVE;
                end
            end

            S_STARVE: begin
                in_ready_c = !hold;
                stop       = hold;
                if (up.in_valid && !hold) begin
                    load    = 1'b1;
                    shift   = 1'b1;
                    cnt_d   = '0;
                    last_d  = up.in_last;
                    pos_d   = pos_q + POS_ONE;
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pos_q   <= pos_d;
        end
    end

    assign up.in_ready = in_ready_c;
    assign win_valid   = shift;
    assign shift_no    = cnt_q;
    assign db_pos      = pos_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_db_shift_ctrl.sv
// Self-checking bench for db_shift_ctrl: a table of single-cycle vectors
// followed by directed multi-cycle passes (boundaries, starvation, hold, reset).
module tb_db_shift_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        hold;
    logic        load;
    logic        shift;
    logic [8:0]  shift_no;
    logic        stop;
    logic        win_valid;
    logic [31:0] db_pos;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    db_shift_ctrl_if up_if ();

    assign up_if.in_valid = in_valid;
    assign up_if.in_last  = in_last;
    assign in_ready       = up_if.in_ready;

    db_shift_ctrl #(.DATA_W(512), .POS_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .up        (up_if.slave),
        .hold      (hold),
        .load      (load),
        .shift     (shift),
        .shift_no  (shift_no),
        .stop      (stop),
        .win_valid (win_valid),
        .db_pos    (db_pos),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Results of the most recent run_pass (cycle 0 = start pulse cycle).
    int r_shifts, r_load_alone, r_load_shift, r_ls_cycle, r_accept_cycle;
    int r_done_cycle, r_done_pos, r_ramp_err, r_hold_good, r_starve_cyc;
    int r_resume0, r_resume1;
    logic r_busy_after, r_done_after;

    // Drives a full pass of n_words words. Optionally drops in_valid for
    // `gap` cycles from the cycle word 1 reaches nucleotide 255, or asserts
    // hold for hold_len cycles when word 1 reaches nucleotide hold_cnt.
    task automatic run_pass(input int n_words, input int gap, input int hold_cnt, input int hold_len);
        int k, acc, exp_idx, gap_left, hold_left, hold_phase;
        bit gap_started, finished, acc_inc;
        logic [31:0] pos_frozen;
        r_shifts = 0; r_load_alone = 0; r_load_shift = 0; r_ls_cycle = -1;
        r_accept_cycle = -1; r_done_cycle = -1; r_done_pos = -1; r_ramp_err = 0;
        r_hold_good = 0; r_starve_cyc = 0; r_resume0 = -1; r_resume1 = -1;
        acc = 0; exp_idx = 0; gap_left = 0; hold_left = 0; hold_phase = 0;
        gap_started = 0; finished = 0; pos_frozen = '0;

        start = 1'b1; in_valid = 1'b0; in_last = 1'b0; hold = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!finished && k < 1200) begin
            // Stimulus decisions use registered outputs only.
            if (!gap_started && gap > 0 && acc == 1 && shift_no == 9'd255) begin
                gap_started = 1;
                gap_left    = gap;
            end
            if (hold_phase == 0 && hold_len > 0 && acc == 1 && busy && shift_no == hold_cnt[8:0]) begin
                hold_phase = 1;
                hold_left  = hold_len;
                pos_frozen = db_pos;
            end
            if (hold_phase == 1 && hold_left == 0)
                hold_phase = 2;
            hold     = (hold_left > 0);
            in_valid = (acc < n_words) && (gap_left == 0);
            in_last  = (acc == n_words - 1);
            #1;
            acc_inc = 0;
            if (load && !shift) r_load_alone++;
            if (load && shift) begin
                r_load_shift++;
                r_ls_cycle = k;
            end
            if (in_valid && in_ready) begin
                if (acc == 0) r_accept_cycle = k;
                acc_inc = 1;
            end
            if (win_valid !== shift) r_ramp_err++;
            if (shift) begin
                if (shift_no != 9'(exp_idx % 256) || db_pos != 32'(exp_idx)) r_ramp_err++;
                exp_idx++;
                r_shifts++;
            end
            if (hold_left > 0) begin
                if (stop && !shift && !load && !in_ready && shift_no == hold_cnt[8:0] && db_pos == pos_frozen)
                    r_hold_good++;
            end
            if (hold_phase == 2) begin
                r_resume0  = shift ? int'(shift_no) : 511;
                hold_phase = 3;
            end else if (hold_phase == 3) begin
                r_resume1  = int'(shift_no);
                hold_phase = 4;
            end
            if (gap_left > 0 && !shift && !load && busy && shift_no == 9'd255)
                r_starve_cyc++;
            if (done) begin
                r_done_cycle = k;
                r_done_pos   = int'(db_pos);
                finished     = 1;
            end
            @(negedge clk);
            k++;
            if (acc_inc) acc++;
            if (gap_left > 0) gap_left--;
            if (hold_left > 0) hold_left--;
        end
        check("pass_timeout", 64'(finished), 64'd1);
        in_valid = 1'b0; in_last = 1'b0; hold = 1'b0;
        #1;
        r_busy_after = busy;
        r_done_after = done;
    endtask

    typedef struct {
        logic       start, in_valid, in_last, hold;
        logic       e_load, e_shift, e_ready, e_stop, e_busy, e_done;
        logic [8:0] e_sno;
        logic [31:0] e_pos;
    } vec_t;

    vec_t vecs[10];
    int   guard;

    initial begin
        // start, valid, last, hold | load, shift, ready, stop, busy, done, shift_no, db_pos
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0}; // reset state
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0}; // idle ignores inputs
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0}; // start pulse
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 32'd0}; // fill waits, hold ignored
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 32'd0}; // fill loads alone
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 32'd0}; // first shift
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd1, 32'd1}; // hold freezes
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd1, 32'd1}; // start in run ignored
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2, 32'd2};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd3, 32'd3}; // valid mid-word not taken

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start    = vecs[i].start;
            in_valid = vecs[i].in_valid;
            in_last  = vecs[i].in_last;
            hold     = vecs[i].hold;
            #1;
            check($sformatf("vec%0d", i),
                  {load, shift, win_valid, in_ready, stop, busy, done, shift_no, db_pos},
                  {vecs[i].e_load, vecs[i].e_shift, vecs[i].e_shift, vecs[i].e_ready, vecs[i].e_stop,
                   vecs[i].e_busy, vecs[i].e_done, vecs[i].e_sno, vecs[i].e_pos});
            @(negedge clk);
        end

        // Single word, no hold: fill at 1, shifts at 2..257, done at 258.
        do_reset();
        run_pass(1, 0, 0, 0);
        check("A_load_alone", r_load_alone, 1);
        check("A_load_shift", r_load_shift, 0);
        check("A_shifts", r_shifts, 256);
        check("A_ramp", r_ramp_err, 0);
        check("A_done_cycle", r_done_cycle, 258);
        check("A_done_pos", r_done_pos, 256);
        check("A_busy_after", r_busy_after, 0);
        check("A_done_width", r_done_after, 0);

        // Two words back to back: boundary at cycle 257, done 514 after start.
        run_pass(2, 0, 0, 0);
        check("B_load_alone", r_load_alone, 1);
        check("B_load_shift", r_load_shift, 1);
        check("B_ls_cycle", r_ls_cycle, 257);
        check("B_shifts", r_shifts, 512);
        check("B_done_pos", r_done_pos, 512);
        check("B_done_from_start", r_done_cycle, 514);
        check("B_done_from_accept", r_done_cycle - r_accept_cycle, 513);
        check("B_ramp", r_ramp_err, 0);

        // Starvation: in_valid low for 7 cycles starting at nucleotide 255.
        run_pass(2, 7, 0, 0);
        check("C_starve_cycles", r_starve_cyc, 7);
        check("C_ls_cycle", r_ls_cycle, 264);
        check("C_load_shift", r_load_shift, 1);
        check("C_done_cycle", r_done_cycle, 521);
        check("C_shifts", r_shifts, 512);
        check("C_ramp", r_ramp_err, 0);

        // Hold for 5 cycles at nucleotide 100.
        run_pass(1, 0, 100, 5);
        check("D_hold_cycles", r_hold_good, 5);
        check("D_resume_shift_at", r_resume0, 100);
        check("D_resume_next", r_resume1, 101);
        check("D_done_cycle", r_done_cycle, 263);
        check("D_done_pos", r_done_pos, 256);
        check("D_ramp", r_ramp_err, 0);

        // Hold for 3 cycles coincident with the boundary, next word waiting.
        run_pass(2, 0, 255, 3);
        check("E_hold_cycles", r_hold_good, 3);
        check("E_ls_cycle", r_ls_cycle, 260);
        check("E_load_shift", r_load_shift, 1);
        check("E_done_cycle", r_done_cycle, 517);
        check("E_shifts", r_shifts, 512);
        check("E_ramp", r_ramp_err, 0);

        // Reset mid-pass, with a stray start pulse during RUN beforehand.
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (shift_no != 9'd20 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("R_reach20", 64'(guard < 100), 64'd1);
        start = 1'b1;
        #1;
        check("R_run_at_start", {busy, shift}, 2'b11);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("R_start_ignored", {busy, shift_no, db_pos}, {1'b1, 9'd21, 32'd21});
        guard = 0;
        while (shift_no != 9'd40 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("R_reach40", 64'(guard < 100), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; hold = 1'b1;
        #1;
        check("R_outputs_zero",
              {load, shift, win_valid, in_ready, stop, busy, done, shift_no, db_pos}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0; hold = 1'b0;
        run_pass(1, 0, 0, 0);
        check("R_restart_pos", r_done_pos, 256);
        check("R_restart_ramp", r_ramp_err, 0);
        check("R_restart_shifts", r_shifts, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
